// File: rtl/adpcm_pkg.sv
// Shared ADPCM decode types, widths and the IMA step table.
package adpcm_pkg;

  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned CODE_W       = 4;
  localparam int unsigned INDEX_W      = 7;
  localparam int unsigned STEP_W       = 15;
  localparam int unsigned STEP_TBL_LEN = 89;

  localparam logic [INDEX_W-1:0] INDEX_MAX = 7'd88;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] pred;
    logic        [INDEX_W-1:0]  index;
  } adpcm_ctx_t;

  localparam int STEP_TBL [STEP_TBL_LEN] = '{
        7,     8,     9,    10,    11,    12,    13,    14,    16,    17,
       19,    21,    23,    25,    28,    31,    34,    37,    41,    45,
       50,    55,    60,    66,    73,    80,    88,    97,   107,   118,
      130,   143,   157,   173,   190,   209,   230,   253,   279,   307,
      337,   371,   408,   449,   494,   544,   598,   658,   724,   796,
      876,   963,  1060,  1166,  1282,  1411,  1552,  1707,  1878,  2066,
     2272,  2499,  2749,  3024,  3327,  3660,  4026,  4428,  4871,  5358,
     5894,  6484,  7132,  7845,  8630,  9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  // Indices beyond the table can only come from a corrupted context; pin them to the last step.
  function automatic logic [STEP_W-1:0] step_lookup(input logic [INDEX_W-1:0] idx);
    if (idx > INDEX_MAX) return STEP_W'(STEP_TBL[STEP_TBL_LEN-1]);
    return STEP_W'(STEP_TBL[idx]);
  endfunction

endpackage

// File: rtl/inverse_quantizer.sv
// IMA ADPCM inverse quantizer: applies one 4-bit code to the predicted sample, saturating to 16 bits.
module inverse_quantizer
  import adpcm_pkg::*;
(
  input  logic        [CODE_W-1:0]   code_i,
  input  logic signed [SAMPLE_W-1:0] pred_i,
  input  logic        [STEP_W-1:0]   step_i,
  output logic signed [SAMPLE_W-1:0] pred_o
);

  logic        [16:0] diff;
  logic signed [17:0] pred_ext;
  logic signed [17:0] sum;

  // Build the magnitude from the code bits, apply the sign bit, then saturate.
  always_comb begin
    diff = 17'(step_i >> 3);
    if (code_i[2]) diff = diff + 17'(step_i);
    if (code_i[1]) diff = diff + 17'(step_i >> 1);
    if (code_i[0]) diff = diff + 17'(step_i >> 2);
    pred_ext = 18'(pred_i);
    if (code_i[3]) sum = pred_ext - $signed({1'b0, diff});
    else           sum = pred_ext + $signed({1'b0, diff});
    if (sum > 18'sd32767)       pred_o = 16'sh7FFF;
    else if (sum < -18'sd32768) pred_o = 16'sh8000;
    else                        pred_o = 16'(sum);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that moves past each winner.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      pos;

  // First requester at or after the pointer wins, wrapping around.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    pos         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(ptr_q) + i;
      if (pos >= N) pos = pos - N;
      if (!found && req_i[pos]) begin
        found         = 1'b1;
        grant_o[pos]  = 1'b1;
        grant_idx_o   = IDX_W'(pos);
      end
    end
  end

  // Pointer moves to the slot after the winner; held when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      if (32'(grant_idx_o) == N - 1) ptr_d = '0;
      else                           ptr_d = grant_idx_o + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/step_adapter.sv
// IMA ADPCM step-index adapter: moves the index by the code magnitude, clamped to the table range.
module step_adapter
  import adpcm_pkg::*;
(
  input  logic [CODE_W-1:0]  code_i,
  input  logic [INDEX_W-1:0] index_i,
  output logic [INDEX_W-1:0] index_o
);

  logic signed [8:0] adj;
  logic signed [8:0] sum;

  // Index adjustment from the magnitude bits, then clamp to [0, INDEX_MAX].
  always_comb begin
    unique case (code_i[2:0])
      3'd4:    adj = 9'sd2;
      3'd5:    adj = 9'sd4;
      3'd6:    adj = 9'sd6;
      3'd7:    adj = 9'sd8;
      default: adj = -9'sd1;
    endcase
    sum = $signed({2'b00, index_i}) + adj;
    if (sum < 9'sd0)                            index_o = '0;
    else if (sum > $signed({2'b00, INDEX_MAX})) index_o = INDEX_MAX;
    else                                        index_o = 7'(sum);
  end

endmodule

// File: rtl/adpcm_chan_scheduler.sv
// Time-shares one ADPCM decode datapath across NUM_CH code streams with per-channel context.
module adpcm_chan_scheduler
  import adpcm_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [CODE_W*NUM_CH-1:0]   in_code,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH-1:0]          chan_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic [CH_W-1:0]            out_chan
);

  adpcm_ctx_t                 ctx_q [NUM_CH];
  adpcm_ctx_t                 ctx_d [NUM_CH];
  logic                       out_valid_q, out_valid_d;
  logic signed [SAMPLE_W-1:0] out_sample_q, out_sample_d;
  logic [CH_W-1:0]            out_chan_q, out_chan_d;

  logic                       can_issue;
  logic [NUM_CH-1:0]          arb_req;
  logic [NUM_CH-1:0]          grant;
  logic [CH_W-1:0]            grant_idx;
  logic                       gnt_any;
  adpcm_ctx_t                 sel_ctx;
  logic [CODE_W-1:0]          sel_code;
  logic [STEP_W-1:0]          sel_step;
  logic signed [SAMPLE_W-1:0] next_pred;
  logic [INDEX_W-1:0]         next_index;

  // Arbitrate only when the output register can take a new sample; a clearing channel sits out.
  always_comb begin
    can_issue = !out_valid_q || out_ready;
    arb_req   = (can_issue && !reset) ? (in_valid & ~chan_clr) : '0;
  end

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (arb_req),
    .advance_i   (can_issue),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Select the granted channel's context and code for the shared datapath.
  always_comb begin
    gnt_any  = |grant;
    sel_ctx  = ctx_q[grant_idx];
    sel_code = in_code[grant_idx*CODE_W +: CODE_W];
    sel_step = step_lookup(sel_ctx.index);
  end

  inverse_quantizer u_iq (
    .code_i (sel_code),
    .pred_i (sel_ctx.pred),
    .step_i (sel_step),
    .pred_o (next_pred)
  );

  step_adapter u_sa (
    .code_i  (sel_code),
    .index_i (sel_ctx.index),
    .index_o (next_index)
  );

  // Next context and output register contents; clear wins over grant for the same channel.
  always_comb begin
    ctx_d        = ctx_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    out_chan_d   = out_chan_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (chan_clr[c]) begin
        ctx_d[c] = '0;
      end else if (grant[c]) begin
        ctx_d[c].pred  = next_pred;
        ctx_d[c].index = next_index;
      end
    end
    if (gnt_any) begin
      out_valid_d  = 1'b1;
      out_sample_d = next_pred;
      out_chan_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Context array and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) ctx_q[c] <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_chan_q   <= '0;
    end else begin
      ctx_q        <= ctx_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_chan_q   <= out_chan_d;
    end
  end

  assign in_ready   = grant;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_chan   = out_chan_q;

endmodule
